// File: rtl/hram_pkg.sv
// Shared types and the command/address builder for the HyperRAM transaction arbiter.
package hram_pkg;

  typedef enum logic [1:0] {
    RDREG = 2'd0,
    WRREG = 2'd1,
    RDMEM = 2'd2,
    WRMEM = 2'd3
  } txn_type_e;

  localparam int CA_RW = 47;
  localparam int CA_AS = 46;
  localparam int CA_BT = 45;

  // addr is a zero-extended word address; bits [15:3] of the CA word stay reserved.
  function automatic logic [47:0] build_ca(input logic write, input logic is_reg,
                                           input logic linear, input logic [31:0] addr);
    logic [47:0] ca;
    ca        = '0;
    ca[CA_RW] = ~write;
    ca[CA_AS] = is_reg;
    ca[CA_BT] = is_reg ? 1'b0 : linear;
    ca[44:16] = addr[31:3];
    ca[2:0]   = addr[2:0];
    return ca;
  endfunction

endpackage

// File: rtl/hram_txn_arbiter_if.sv
// Requester and engine-side bundle of the HyperRAM transaction arbiter.
interface hram_txn_arbiter_if #(
  parameter int NREQ = 3,
  parameter int AW   = 32
);
  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ-1:0]    req_write;
  logic [NREQ-1:0]    req_reg;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ-1:0]    req_done;
  logic [NREQ-1:0]    req_err;
  logic [3:0]         eng_start;
  logic [3:0]         eng_end;
  logic [47:0]        casig;
  logic [GW-1:0]      grant_id;
  logic               busy;

  modport master (
    output req_valid, req_write, req_reg, req_addr, eng_end,
    input  req_ready, req_done, req_err, eng_start, casig, grant_id, busy
  );

  modport slave (
    input  req_valid, req_write, req_reg, req_addr, eng_end,
    output req_ready, req_done, req_err, eng_start, casig, grant_id, busy
  );
endinterface

// File: rtl/hram_txn_arbiter_rr.sv
// Combinational round-robin pick: first requester above last_grant, wrapping modulo NREQ.
module rr_arbiter #(
  parameter int NREQ = 3,
  localparam int GW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [GW-1:0]   last_grant,
  output logic [NREQ-1:0] gnt,
  output logic [GW-1:0]   gnt_idx,
  output logic            gnt_any
);

  int            idx;
  logic [GW-1:0] sel;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    idx     = 0;
    sel     = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = int'(last_grant) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      sel = GW'(idx);
      if (!gnt_any && req[sel]) begin
        gnt_any  = 1'b1;
        gnt_idx  = sel;
        gnt[sel] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hram_txn_arbiter.sv
// Round-robin front end for the four HyperRAM engines with CS# recovery gap.
// Define HRAM_ARB_WATCHDOG_EN to add the ISSUE watchdog, ABORT state and wd_fired port.
module hram_txn_arbiter
  import hram_pkg::*;
#(
  parameter int NREQ       = 3,
  parameter int AW         = 32,
  parameter int TRWR       = 4,
  parameter int MEM_LINEAR = 1,
  parameter int TIMEOUT    = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  hram_txn_arbiter_if.slave bus
`ifdef HRAM_ARB_WATCHDOG_EN
  ,
  output logic              wd_fired
`endif
);

  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (TRWR > 1) ? $clog2(TRWR + 1) : 1;

`ifdef HRAM_ARB_WATCHDOG_EN
  typedef enum logic [1:0] {IDLE, ISSUE, RECOVER, ABORT} state_e;
  localparam int WW = $clog2(TIMEOUT + 1);
`else
  typedef enum logic [1:0] {IDLE, ISSUE, RECOVER} state_e;
`endif

  state_e          state_q, state_d;
  txn_type_e       type_q, type_d;
  logic [GW-1:0]   grant_q, grant_d;
  logic [GW-1:0]   last_q, last_d;
  logic [47:0]     ca_q, ca_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      start_q, start_d;
  logic [NREQ-1:0] done_q, done_d;

  logic [NREQ-1:0] arb_gnt;
  logic [GW-1:0]   arb_idx;
  logic            arb_any;
  logic [31:0]     addr_sel;

`ifdef HRAM_ARB_WATCHDOG_EN
  logic [WW-1:0]   wd_q;
  logic [NREQ-1:0] err_q, err_d;
  logic            wd_fired_q;
`endif

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req       (bus.req_valid),
    .last_grant(last_q),
    .gnt       (arb_gnt),
    .gnt_idx   (arb_idx),
    .gnt_any   (arb_any)
  );

  always_comb begin
    addr_sel         = '0;
    addr_sel[AW-1:0] = bus.req_addr[arb_idx*AW +: AW];
  end

  always_comb begin
    state_d       = state_q;
    type_d        = type_q;
    grant_d       = grant_q;
    last_d        = last_q;
    ca_d          = ca_q;
    cnt_d         = cnt_q;
    start_d       = start_q;
    done_d        = '0;
    bus.req_ready = '0;
`ifdef HRAM_ARB_WATCHDOG_EN
    err_d         = '0;
`endif
    case (state_q)
      IDLE: begin
        bus.req_ready = arb_gnt;
        // ready is the arbiter grant, so any grant is a completed handshake
        if (arb_any) begin
          type_d  = txn_type_e'({~bus.req_reg[arb_idx], bus.req_write[arb_idx]});
          grant_d = arb_idx;
          last_d  = arb_idx;
          ca_d    = build_ca(bus.req_write[arb_idx], bus.req_reg[arb_idx],
                             (MEM_LINEAR != 0), addr_sel);
          start_d = 4'b0001 << type_d;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.eng_end[type_q]) begin
          start_d = '0;
          done_d  = NREQ'(1) << grant_q;
          if (TRWR == 0) begin
            state_d = IDLE;
          end else begin
            state_d = RECOVER;
            cnt_d   = CW'(TRWR);
          end
        end
`ifdef HRAM_ARB_WATCHDOG_EN
        else if (wd_q == WW'(TIMEOUT - 1)) begin
          start_d = '0;
          err_d   = NREQ'(1) << grant_q;
          state_d = ABORT;
        end
`endif
      end
      RECOVER: begin
        if (cnt_q <= CW'(1)) state_d = IDLE;
        else                 cnt_d   = cnt_q - CW'(1);
      end
`ifdef HRAM_ARB_WATCHDOG_EN
      ABORT: begin
        if (TRWR == 0) begin
          state_d = IDLE;
        end else begin
          state_d = RECOVER;
          cnt_d   = CW'(TRWR);
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // State register: casig and grant_id are cleared by reset, so data is reset too
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      type_q  <= RDREG;
      grant_q <= '0;
      last_q  <= GW'(NREQ - 1);
      ca_q    <= '0;
      cnt_q   <= '0;
      start_q <= '0;
      done_q  <= '0;
    end else begin
      state_q <= state_d;
      type_q  <= type_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      ca_q    <= ca_d;
      cnt_q   <= cnt_d;
      start_q <= start_d;
      done_q  <= done_d;
    end
  end

`ifdef HRAM_ARB_WATCHDOG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_q       <= '0;
      err_q      <= '0;
      wd_fired_q <= 1'b0;
    end else begin
      wd_q  <= (state_q == ISSUE) ? wd_q + WW'(1) : '0;
      err_q <= err_d;
      if (state_d == ABORT) wd_fired_q <= 1'b1;
    end
  end

  assign bus.req_err = err_q;
  assign wd_fired    = wd_fired_q;
`else
  assign bus.req_err = '0;
`endif

  assign bus.eng_start = start_q;
  assign bus.req_done  = done_q;
  assign bus.casig     = ca_q;
  assign bus.grant_id  = grant_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_hram_txn_arbiter.sv
// Directed scoreboard bench for hram_txn_arbiter (TRWR=4 and TRWR=0 instances).
module tb_hram_txn_arbiter;
  import hram_pkg::*;

  localparam int NREQ = 3;
  localparam int AW   = 32;
  localparam int GW   = 2;

  typedef struct packed {
    logic [GW-1:0] id;
    logic [3:0]    start;
    logic [47:0]   ca;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  hram_txn_arbiter_if #(.NREQ(NREQ), .AW(AW)) bus0 ();
  hram_txn_arbiter_if #(.NREQ(NREQ), .AW(AW)) bus1 ();

`ifdef HRAM_ARB_WATCHDOG_EN
  logic wd0, wd1;
`endif

  hram_txn_arbiter #(.NREQ(NREQ), .AW(AW), .TRWR(4), .MEM_LINEAR(1), .TIMEOUT(16)) dut0 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus0)
`ifdef HRAM_ARB_WATCHDOG_EN
    ,
    .wd_fired(wd0)
`endif
  );

  hram_txn_arbiter #(.NREQ(NREQ), .AW(AW), .TRWR(0), .MEM_LINEAR(1), .TIMEOUT(16)) dut1 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus1)
`ifdef HRAM_ARB_WATCHDOG_EN
    ,
    .wd_fired(wd1)
`endif
  );

  function automatic logic [47:0] model_ca(input bit w, input bit r, input logic [31:0] a);
    return {~w, r, (r ? 1'b0 : 1'b1), a[31:3], 13'd0, a[2:0]};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int which, input logic [1:0] i, input bit v, input bit w,
                         input bit r, input logic [31:0] a);
    if (which == 0) begin
      bus0.req_valid[i] = v; bus0.req_write[i] = w; bus0.req_reg[i] = r;
      bus0.req_addr[i*AW +: AW] = a;
    end else begin
      bus1.req_valid[i] = v; bus1.req_write[i] = w; bus1.req_reg[i] = r;
      bus1.req_addr[i*AW +: AW] = a;
    end
  endtask

  task automatic pop_check(input int which, input string tag, output logic [GW-1:0] id);
    exp_t e;
    id = '0;
    if (sb.size() == 0) begin
      check({tag, "_sb_underrun"}, 64'(sb.size()), 64'd1);
    end else begin
      e  = sb.pop_front();
      id = e.id;
      check({tag, "_start"}, 64'(which == 0 ? bus0.eng_start : bus1.eng_start), 64'(e.start));
      check({tag, "_casig"}, 64'(which == 0 ? bus0.casig : bus1.casig), 64'(e.ca));
      check({tag, "_grant"}, 64'(which == 0 ? bus0.grant_id : bus1.grant_id), 64'(e.id));
    end
  endtask

  task automatic wait_start(input int which, output int at);
    at = -1;
    for (int n = 0; n < 64; n++) begin
      @(negedge clk);
      if ((which == 0 ? bus0.eng_start : bus1.eng_start) != 4'd0) begin
        at = cyc;
        break;
      end
    end
    check("start_seen", 64'(at >= 0), 64'd1);
  endtask

  task automatic wait_idle();
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 32; n++) begin
      @(negedge clk);
      if (!bus0.busy) begin
        seen = 1'b1;
        break;
      end
    end
    check("idle_seen", 64'(seen), 64'd1);
  endtask

  // Pulse eng_end[t] for one cycle on bus0 and check the completion pulse to requester id.
  task automatic finish_txn(input logic [1:0] t, input logic [GW-1:0] id, output int end_cyc);
    @(posedge clk); #1 bus0.eng_end[t] = 1'b1;
    @(negedge clk); end_cyc = cyc;
    @(posedge clk); #1 bus0.eng_end = '0;
    @(negedge clk);
    check("done_pulse", 64'(bus0.req_done), 64'(3'b001 << id));
    check("start_clr", 64'(bus0.eng_start), 64'd0);
    check("err_quiet", 64'(bus0.req_err), 64'd0);
    @(negedge clk);
    check("done_once", 64'(bus0.req_done), 64'd0);
  endtask

  initial begin
    int            s_cyc, e_cyc, lg;
    logic [GW-1:0] id;
    logic [31:0]   fa[NREQ];

    bus0.req_valid = '0; bus0.req_write = '0; bus0.req_reg = '0; bus0.req_addr = '0;
    bus0.eng_end   = '0;
    bus1.req_valid = '0; bus1.req_write = '0; bus1.req_reg = '0; bus1.req_addr = '0;
    bus1.eng_end   = '0;
    e_cyc = 0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_start", 64'(bus0.eng_start), 64'd0);
    check("rst_done", 64'(bus0.req_done), 64'd0);
    check("rst_casig", 64'(bus0.casig), 64'd0);
    check("rst_grant", 64'(bus0.grant_id), 64'd0);
    check("rst_busy", 64'(bus0.busy), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // memory read by requester 0
    @(posedge clk); #1 set_req(0, 2'd0, 1'b1, 1'b0, 1'b0, 32'h0000_1234);
    @(negedge clk);
    check("t1_ready", 64'(bus0.req_ready), 64'b001);
    sb.push_back('{id: 2'd0, start: 4'b0100, ca: 48'hA000_0246_0004});
    @(posedge clk); #1 bus0.req_valid[0] = 1'b0;
    @(negedge clk);
    pop_check(0, "t1", id);
    check("t1_busy", 64'(bus0.busy), 64'd1);
    finish_txn(2'd2, id, e_cyc);
    wait_idle();

    // register read by requester 1 with a stray end flag
    @(posedge clk); #1 set_req(0, 2'd1, 1'b1, 1'b0, 1'b1, 32'h0000_0001);
    @(negedge clk);
    check("t2_ready", 64'(bus0.req_ready), 64'b010);
    sb.push_back('{id: 2'd1, start: 4'b0001, ca: 48'hC000_0000_0001});
    @(posedge clk); #1 bus0.req_valid[1] = 1'b0;
    @(negedge clk);
    pop_check(0, "t2", id);
    @(posedge clk); #1 bus0.eng_end = 4'b1000;
    @(posedge clk); #1 bus0.eng_end = 4'b0000;
    @(negedge clk);
    check("t2_stray_start", 64'(bus0.eng_start), 64'b0001);
    check("t2_stray_done", 64'(bus0.req_done), 64'd0);
    finish_txn(2'd0, id, e_cyc);
    wait_idle();

    // all three hold valid: rotation continues after last grant 1
    for (int i = 0; i < NREQ; i++) fa[i] = 32'h100 * (i + 1) + 32'(i);
    @(posedge clk); #1
    for (int i = 0; i < NREQ; i++) set_req(0, 2'(i), 1'b1, 1'b1, 1'b0, fa[i]);
    lg = 1;
    for (int k = 0; k < 6; k++) begin
      lg = (lg + 1) % NREQ;
      sb.push_back('{id: GW'(lg), start: 4'b1000, ca: model_ca(1'b1, 1'b0, fa[lg])});
    end
    for (int k = 0; k < 6; k++) begin
      wait_start(0, s_cyc);
      if (k > 0) check("rr_gap", 64'(s_cyc - e_cyc), 64'd6);
      pop_check(0, "rr", id);
      finish_txn(2'd3, id, e_cyc);
    end
    @(posedge clk); #1 bus0.req_valid = '0;
    wait_idle();

    // memory write by requester 2, reset mid-ISSUE
    @(posedge clk); #1 set_req(0, 2'd2, 1'b1, 1'b1, 1'b0, 32'h0000_0010);
    @(negedge clk);
    check("t4_ready", 64'(bus0.req_ready), 64'b100);
    sb.push_back('{id: 2'd2, start: 4'b1000, ca: 48'h2000_0002_0000});
    @(posedge clk); #1 bus0.req_valid[2] = 1'b0;
    @(negedge clk);
    pop_check(0, "t4", id);
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    check("t4_rst_start", 64'(bus0.eng_start), 64'd0);
    check("t4_rst_busy", 64'(bus0.busy), 64'd0);
    check("t4_rst_casig", 64'(bus0.casig), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      check("t4_no_done", 64'(bus0.req_done), 64'd0);
    end
    @(posedge clk); #1
    for (int i = 0; i < NREQ; i++) set_req(0, 2'(i), 1'b1, 1'b0, 1'b0, 32'(i * 8));
    @(negedge clk);
    check("t4_first_ready", 64'(bus0.req_ready), 64'b001);
    sb.push_back('{id: 2'd0, start: 4'b0100, ca: model_ca(1'b0, 1'b0, 32'd0)});
    @(posedge clk); #1 bus0.req_valid = '0;
    @(negedge clk);
    pop_check(0, "t4_after", id);
    finish_txn(2'd2, id, e_cyc);
    wait_idle();

    // TRWR=0: requester 0 back-to-back
    @(posedge clk); #1 set_req(1, 2'd0, 1'b1, 1'b0, 1'b0, 32'h0000_0040);
    sb.push_back('{id: 2'd0, start: 4'b0100, ca: model_ca(1'b0, 1'b0, 32'h40)});
    sb.push_back('{id: 2'd0, start: 4'b0100, ca: model_ca(1'b0, 1'b0, 32'h40)});
    wait_start(1, s_cyc);
    pop_check(1, "b2b_a", id);
    @(posedge clk); #1 bus1.eng_end = 4'b0100;
    @(negedge clk); e_cyc = cyc;
    @(posedge clk); #1 bus1.eng_end = '0;
    @(negedge clk);
    check("b2b_done", 64'(bus1.req_done), 64'b001);
    check("b2b_start_clr", 64'(bus1.eng_start), 64'd0);
    wait_start(1, s_cyc);
    check("b2b_gap", 64'(s_cyc - e_cyc), 64'd2);
    pop_check(1, "b2b_b", id);
    @(posedge clk); #1 bus1.req_valid = '0; bus1.eng_end = 4'b0100;
    @(posedge clk); #1 bus1.eng_end = '0;
    @(negedge clk);
    check("b2b_done2", 64'(bus1.req_done), 64'b001);

`ifdef HRAM_ARB_WATCHDOG_EN
    // engine never ends: watchdog aborts after 16 ISSUE cycles
    @(posedge clk); #1 set_req(0, 2'd1, 1'b1, 1'b0, 1'b0, 32'h0000_0020);
    sb.push_back('{id: 2'd1, start: 4'b0100, ca: model_ca(1'b0, 1'b0, 32'h20)});
    @(posedge clk); #1 bus0.req_valid[1] = 1'b0;
    @(negedge clk);
    pop_check(0, "wd", id);
    repeat (15) @(negedge clk);
    check("wd_still_start", 64'(bus0.eng_start), 64'b0100);
    @(negedge clk);
    check("wd_start_clr", 64'(bus0.eng_start), 64'd0);
    check("wd_err", 64'(bus0.req_err), 64'b010);
    check("wd_no_done", 64'(bus0.req_done), 64'd0);
    check("wd_fired", 64'(wd0), 64'd1);
    @(negedge clk);
    check("wd_err_once", 64'(bus0.req_err), 64'd0);
    wait_idle();
    @(posedge clk); #1 set_req(0, 2'd0, 1'b1, 1'b1, 1'b0, 32'h0000_0030);
    @(negedge clk);
    check("wd_next_ready", 64'(bus0.req_ready), 64'b001);
    sb.push_back('{id: 2'd0, start: 4'b1000, ca: model_ca(1'b1, 1'b0, 32'h30)});
    @(posedge clk); #1 bus0.req_valid[0] = 1'b0;
    @(negedge clk);
    pop_check(0, "wd_next", id);
    finish_txn(2'd3, id, e_cyc);
    check("wd_sticky", 64'(wd0), 64'd1);
`endif

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "bench timeout");
  end

endmodule
